// File: rtl/pcileech_pwrctl_pkg.sv
// Shared types and constants for the PCIe reset/presence controller.
// State encoding is visible on the pwr_state output, so it must not change.
package pcileech_pwrctl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        OFF  = 2'd2,
        HOLD = 2'd3
    } pwr_state_t;

    localparam int PWR_MODE_OFF     = 0;
    localparam int PWR_MODE_ONESHOT = 1;
    localparam int PWR_MODE_CONT    = 2;

    // PERST# is forced low only while the card is powered off or re-arming.
    function automatic logic gates_perst(input pwr_state_t s);
        return (s == OFF) || (s == HOLD);
    endfunction

endpackage

// File: rtl/pcileech_pwrctl_debounce.sv
// Two-flop synchroniser plus debounce for the Thunderbolt power-detect switch.
// sw_db flips only after the synced level disagrees with it for TICKS consecutive cycles.
module pcileech_pwrctl_debounce #(
    parameter int TICKS = 125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_async,
    output logic sw_db
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= sw_async;
            sync2_reg <= sync1_reg;
        end
    end

    // Any agreement between synced level and output restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            db_reg  <= ~db_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sw_db = db_reg;

endmodule

// File: rtl/pcileech_pcie_pwrctl.sv
// PCIe reset/presence controller: aggregates board pins and gates PERST# from the power switch.
// Optional PCILEECH_PWRCTL_FORCE_EN adds a force_rearm input for software-triggered PERST# pulses.
module pcileech_pcie_pwrctl
    import pcileech_pwrctl_pkg::*;
#(
    parameter int              NUM_CH         = 2,
    parameter int              POWER_SW_MODE  = 0,
    parameter longint unsigned POWER_SW_TIME  = 60 * 64'd125_000_000,
    parameter int              DEBOUNCE_TICKS = 125_000,
    parameter longint unsigned REARM_TICKS    = 64'd12_500_000,
    parameter int              CNT_W          = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_sw,
    input  logic [NUM_CH-1:0] pcie_present_in,
    input  logic [NUM_CH-1:0] pcie_perst_in_n,
    output logic              pcie_present,
    output logic              pcie_perst_n,
    output logic              sw_db,
    output logic [1:0]        pwr_state,
    output logic [15:0]       disable_count
`ifdef PCILEECH_PWRCTL_FORCE_EN
    ,
    input  logic              force_rearm
`endif
);

    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(POWER_SW_TIME - 64'd1);
    localparam logic [CNT_W-1:0] REARM_LAST = CNT_W'(REARM_TICKS - 64'd1);
    localparam pwr_state_t RESET_STATE = (POWER_SW_MODE == PWR_MODE_OFF) ? RUN : BOOT;
    localparam logic CONT = (POWER_SW_MODE == PWR_MODE_CONT);

    pwr_state_t       state_reg;
    pwr_state_t       state_next;
    logic             rearm_clr;
    logic             gate;
    logic             force_req;
    logic [CNT_W-1:0] boot_cnt_reg;
    logic [CNT_W-1:0] rearm_cnt_reg;
    logic [15:0]      disable_count_reg;
    logic             present_reg;
    logic             perst_n_reg;

`ifdef PCILEECH_PWRCTL_FORCE_EN
    assign force_req = force_rearm;
`else
    assign force_req = 1'b0;
`endif

    pcileech_pwrctl_debounce #(
        .TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .sw_async (power_sw),
        .sw_db    (sw_db)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Modes 0/1 only reach HOLD through a forced re-arm, and leave it on the timer alone.
    always_comb begin
        state_next = state_reg;
        rearm_clr  = 1'b0;
        case (state_reg)
            BOOT: begin
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = sw_db ? RUN : OFF;
                end
            end
            RUN: begin
                if (force_req) begin
                    state_next = HOLD;
                    rearm_clr  = 1'b1;
                end else if (CONT && !sw_db) begin
                    state_next = OFF;
                end
            end
            OFF: begin
                if (force_req || (CONT && sw_db)) begin
                    state_next = HOLD;
                    rearm_clr  = 1'b1;
                end
            end
            HOLD: begin
                if (CONT && !sw_db) begin
                    state_next = OFF;
                end else if (force_req) begin
                    rearm_clr = 1'b1;
                end else if (rearm_cnt_reg == REARM_LAST) begin
                    state_next = RUN;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    always_comb begin
        gate = gates_perst(state_reg);
    end

    // Boot counter parks at the decision value so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_cnt_reg <= '0;
        end else if ((state_reg == BOOT) && (boot_cnt_reg != BOOT_LAST)) begin
            boot_cnt_reg <= boot_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rearm_cnt_reg <= '0;
        end else if (rearm_clr) begin
            rearm_cnt_reg <= '0;
        end else if (state_reg == HOLD) begin
            rearm_cnt_reg <= rearm_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disable_count_reg <= '0;
        end else if ((state_next == OFF) && ((state_reg == RUN) || (state_reg == BOOT))
                     && (disable_count_reg != 16'hFFFF)) begin
            disable_count_reg <= disable_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            present_reg <= 1'b0;
            perst_n_reg <= 1'b0;
        end else begin
            present_reg <= &pcie_present_in;
            perst_n_reg <= (&pcie_perst_in_n) & ~gate;
        end
    end

    assign pcie_present  = present_reg;
    assign pcie_perst_n  = perst_n_reg;
    assign pwr_state     = state_reg;
    assign disable_count = disable_count_reg;

endmodule
